tq_idct_ctrl: RTL

Sequencing controller for the combinational 4x4 inverse-transform datapath (`tq_idct_4x4`) in the H.264 encoder reconstruction loop. It collects dequantised coefficients one row per beat from the dequant stage and fires the IDCT once per 4x4 block. It registers the residual and streams it row by row to reconstruction. It also walks the block order of a macroblock, short-circuits coded-block-flag-zero blocks, and signals macroblock completion.

---
 rtl/tq_idct_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tq_idct_ctrl.sv
// 4x4 inverse-transform sequencer: gathers coefficient rows, fires the
// combinational IDCT, and streams residual rows per block of a macroblock.

module tq_idct_4x4 #(
  parameter int DW = 15
) (
  input  logic [16*DW-1:0] coef_i,
  output logic [16*DW-1:0] res_o
);
  localparam int IW = DW + 6;

  function automatic logic signed [IW-1:0] ext(input logic [DW-1:0] x);
    return {{(IW-DW){x[DW-1]}}, x};
  endfunction

  // 1-D butterfly; y0 lands in the low IW bits.
  function automatic logic [4*IW-1:0] bfly(input logic signed [IW-1:0] x0,
                                            input logic signed [IW-1:0] x1,
                                            input logic signed [IW-1:0] x2,
                                            input logic signed [IW-1:0] x3);
    logic signed [IW-1:0] e0, e1, e2, e3;
    e0 = x0 + x2;
    e1 = x0 - x2;
    e2 = (x1 >>> 1) - x3;
    e3 = x1 + (x3 >>> 1);
    return {e0 - e3, e1 - e2, e1 + e2, e0 + e3};
  endfunction

  always_comb begin
    logic [4*IW-1:0] y;
    logic signed [IW-1:0] h [4][4];
    logic signed [IW-1:0] v [4][4];
    logic signed [IW-1:0] rnd;
    res_o = '0;
    for (int r = 0; r < 4; r++) begin
      y = bfly(ext(coef_i[(r*4+0)*DW +: DW]), ext(coef_i[(r*4+1)*DW +: DW]),
               ext(coef_i[(r*4+2)*DW +: DW]), ext(coef_i[(r*4+3)*DW +: DW]));
      for (int c = 0; c < 4; c++) h[r][c] = y[c*IW +: IW];
    end
    for (int c = 0; c < 4; c++) begin
      y = bfly(h[0][c], h[1][c], h[2][c], h[3][c]);
      for (int r = 0; r < 4; r++) v[r][c] = y[r*IW +: IW];
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rnd = v[r][c] + IW'(32);
        res_o[(r*4+c)*DW +: DW] = rnd[IW-1:6];
      end
    end
  end
endmodule

module tq_idct_ctrl #(
  parameter int DW      = 15,
  parameter int BLK_NUM = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            coef_valid_i,
  output logic            coef_ready_o,
  input  logic [4*DW-1:0] coef_row_i,
  input  logic            coef_cbf_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [4*DW-1:0] res_row_o,
  output logic [4:0]      res_blk_o,
  output logic [1:0]      res_row_idx_o,
  output logic            mb_done_o,
  output logic            busy_o
);
  // IDLE: wait start | LOAD: take rows | CALC: capture IDCT | OUT: stream rows
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             row_q, row_d;
  logic [4:0]             blk_q, blk_d;
  logic [3:0][4*DW-1:0]   ibuf_q, ibuf_d;
  logic [3:0][4*DW-1:0]   obuf_q, obuf_d;
  logic                   coef_ready_q, coef_ready_d;
  logic                   res_valid_q, res_valid_d;
  logic                   mb_done_q, mb_done_d;
  logic                   busy_q, busy_d;
  logic [16*DW-1:0]       idct_res;
  logic                   coef_xfer, res_xfer;

  tq_idct_4x4 #(.DW(DW)) u_idct (
    .coef_i (ibuf_q),
    .res_o  (idct_res)
  );

  assign coef_xfer = coef_ready_q & coef_valid_i;
  assign res_xfer  = res_valid_q & res_ready_i;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    blk_d     = blk_q;
    ibuf_d    = ibuf_q;
    obuf_d    = obuf_q;
    mb_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          blk_d   = '0;
          row_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (coef_xfer) begin
          if (row_q == 2'd0 && !coef_cbf_i) begin
            obuf_d  = '0;
            state_d = S_OUT;
          end else begin
            ibuf_d[row_q] = coef_row_i;
            row_d         = row_q + 2'd1;
            if (row_q == 2'd3) state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        obuf_d  = idct_res;
        state_d = S_OUT;
      end
      S_OUT: begin
        // Row 0 of the buffer is always the row on res_row_o; shift on transfer.
        if (res_xfer) begin
          obuf_d = {{(4*DW){1'b0}}, obuf_q[3], obuf_q[2], obuf_q[1]};
          row_d  = row_q + 2'd1;
          if (row_q == 2'd3) begin
            if (blk_q == 5'(BLK_NUM - 1)) begin
              state_d   = S_IDLE;
              mb_done_d = 1'b1;
            end else begin
              blk_d   = blk_q + 5'd1;
              state_d = S_LOAD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    coef_ready_d = (state_d == S_LOAD);
    res_valid_d  = (state_d == S_OUT);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      blk_q        <= '0;
      ibuf_q       <= '0;
      obuf_q       <= '0;
      coef_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      mb_done_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      blk_q        <= blk_d;
      ibuf_q       <= ibuf_d;
      obuf_q       <= obuf_d;
      coef_ready_q <= coef_ready_d;
      res_valid_q  <= res_valid_d;
      mb_done_q    <= mb_done_d;
      busy_q       <= busy_d;
    end
  end

  assign coef_ready_o  = coef_ready_q;
  assign res_valid_o   = res_valid_q;
  assign res_row_o     = obuf_q[0];
  assign res_blk_o     = blk_q;
  assign res_row_idx_o = row_q;
  assign mb_done_o     = mb_done_q;
  assign busy_o        = busy_q;
endmodule
